coord_dropper: RTL and testbench



---
 rtl/coord_dropper_pkg.sv | 38 +++
 rtl/coord_dropper_reg_fifo.sv | 64 ++++++
 rtl/coord_dropper.sv | 195 +++++++++++++++++++
 tb/tb_coord_dropper.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coord_dropper_pkg.sv
// Token encoding and helpers shared by the coordinate dropper and its bench-facing top.
package coord_dropper_pkg;

  localparam int COORD_W = 16;
  localparam int TOK_W   = COORD_W + 1;
  localparam int LVL_W   = 8;

  localparam logic [TOK_W-1:0] DONE_TOKEN = 17'h10100;
  // Control bit plus the [9:8] field that separates stop (00) from done (01).
  localparam logic [TOK_W-1:0] STOP_MASK  = 17'h10300;
  localparam logic [TOK_W-1:0] STOP_MATCH = 17'h10000;

  typedef enum logic {
    ST_PROCESS = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

  function automatic logic is_data(input logic [TOK_W-1:0] tok);
    return !tok[TOK_W-1];
  endfunction

  function automatic logic is_stop(input logic [TOK_W-1:0] tok);
    return (tok & STOP_MASK) == STOP_MATCH;
  endfunction

  function automatic logic is_done(input logic [TOK_W-1:0] tok);
    return tok == DONE_TOKEN;
  endfunction

  function automatic logic [LVL_W-1:0] stop_level(input logic [TOK_W-1:0] tok);
    return tok[LVL_W-1:0];
  endfunction

  function automatic logic [TOK_W-1:0] make_stop(input logic [LVL_W-1:0] lvl);
    return STOP_MATCH | {{(TOK_W-LVL_W){1'b0}}, lvl};
  endfunction

endpackage

// File: rtl/coord_dropper_reg_fifo.sv
// Small registered ready/valid FIFO used as input and output skid buffer.
module coord_dropper_reg_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clk_en,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_wvalid,
  output logic             o_wready,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  input  logic             i_rready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_wready = (r_count != CNT_W'(DEPTH));
  assign o_rvalid = (r_count != '0);
  assign o_rdata  = r_mem[r_rd_ptr];
  assign w_push   = i_wvalid & o_wready;
  assign w_pop    = i_rready & o_rvalid;

  // Pointer and occupancy bookkeeping; flush empties the buffer like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clk_en) begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (i_clk_en && !i_flush && w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/coord_dropper.sv
// Coordinate dropper: removes outer coordinates whose inner fiber is empty,
// along with that fiber's stop token, merging stop levels where needed.
//
//   state      | meaning
//   ST_PROCESS | normal evaluation of the two input heads
//   ST_DONE    | D on both heads, pending stop already emitted; emit D pair
module coord_dropper
  import coord_dropper_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W:0]   cmrg_coord_in_0,
  input  logic              cmrg_coord_in_0_valid,
  output logic              cmrg_coord_in_0_ready,
  input  logic [DATA_W:0]   cmrg_coord_in_1,
  input  logic              cmrg_coord_in_1_valid,
  output logic              cmrg_coord_in_1_ready,
  output logic [DATA_W:0]   cmrg_coord_out_0,
  output logic              cmrg_coord_out_0_valid,
  input  logic              cmrg_coord_out_0_ready,
  output logic [DATA_W:0]   cmrg_coord_out_1,
  output logic              cmrg_coord_out_1_valid,
  input  logic              cmrg_coord_out_1_ready,
  input  logic              cmrg_mode,
  input  logic              cmrg_enable,
  input  logic [DATA_W-1:0] cmrg_stop_lvl
);

  logic [TOK_W-1:0] w_in0_tok, w_in1_tok, w_out0_tok, w_out1_tok;
  logic             w_in0_vld, w_in1_vld, w_in0_pop, w_in1_pop;
  logic             w_in0_wready, w_in1_wready;
  logic             w_out0_push, w_out1_push, w_out0_space, w_out1_space;
  logic             w_out0_rvalid, w_out1_rvalid;
  state_e           r_state, w_state_nxt;
  logic             r_pend_vld, w_pend_vld_nxt;
  logic [LVL_W-1:0] r_pend_lvl, w_pend_lvl_nxt;
  logic             r_fne, w_fne_nxt;
  logic             w_unused_cfg;

  // Configuration inputs kept for interface compatibility only.
  assign w_unused_cfg = ^{cmrg_enable, cmrg_stop_lvl};

  assign cmrg_coord_in_0_ready  = w_in0_wready & tile_en;
  assign cmrg_coord_in_1_ready  = w_in1_wready & tile_en;
  assign cmrg_coord_out_0_valid = w_out0_rvalid & tile_en;
  assign cmrg_coord_out_1_valid = w_out1_rvalid & tile_en;

  coord_dropper_reg_fifo #(.WIDTH(TOK_W), .DEPTH(FIFO_DEPTH)) u_in0 (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_wdata(cmrg_coord_in_0), .i_wvalid(cmrg_coord_in_0_valid & tile_en),
    .o_wready(w_in0_wready), .o_rdata(w_in0_tok), .o_rvalid(w_in0_vld),
    .i_rready(w_in0_pop));

  coord_dropper_reg_fifo #(.WIDTH(TOK_W), .DEPTH(FIFO_DEPTH)) u_in1 (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_wdata(cmrg_coord_in_1), .i_wvalid(cmrg_coord_in_1_valid & tile_en),
    .o_wready(w_in1_wready), .o_rdata(w_in1_tok), .o_rvalid(w_in1_vld),
    .i_rready(w_in1_pop));

  coord_dropper_reg_fifo #(.WIDTH(TOK_W), .DEPTH(FIFO_DEPTH)) u_out0 (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_wdata(w_out0_tok), .i_wvalid(w_out0_push), .o_wready(w_out0_space),
    .o_rdata(cmrg_coord_out_0), .o_rvalid(w_out0_rvalid),
    .i_rready(cmrg_coord_out_0_ready & tile_en));

  coord_dropper_reg_fifo #(.WIDTH(TOK_W), .DEPTH(FIFO_DEPTH)) u_out1 (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_flush(flush),
    .i_wdata(w_out1_tok), .i_wvalid(w_out1_push), .o_wready(w_out1_space),
    .o_rdata(cmrg_coord_out_1), .o_rvalid(w_out1_rvalid),
    .i_rready(cmrg_coord_out_1_ready & tile_en));

  // Core state: FSM, pending stop and fiber-nonempty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PROCESS;
      r_pend_vld <= 1'b0;
      r_pend_lvl <= '0;
      r_fne      <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_PROCESS;
      r_pend_vld <= 1'b0;
      r_pend_lvl <= '0;
      r_fne      <= 1'b0;
    end else if (clk_en) begin
      r_state    <= w_state_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_lvl <= w_pend_lvl_nxt;
      r_fne      <= w_fne_nxt;
    end
  end

  // One step per cycle on the FIFO heads; a step needing a full output does nothing.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_lvl_nxt = r_pend_lvl;
    w_fne_nxt      = r_fne;
    w_in0_pop      = 1'b0;
    w_in1_pop      = 1'b0;
    w_out0_push    = 1'b0;
    w_out1_push    = 1'b0;
    w_out0_tok     = w_in0_tok;
    w_out1_tok     = w_in1_tok;
    if (tile_en) begin
      if (!cmrg_mode) begin
        if (w_in0_vld && w_out0_space) begin
          w_out0_push = 1'b1;
          w_in0_pop   = 1'b1;
        end
        if (w_in1_vld && w_out1_space) begin
          w_out1_push = 1'b1;
          w_in1_pop   = 1'b1;
        end
      end else begin
        case (r_state)
          ST_PROCESS: begin
            if (w_in1_vld && is_done(w_in1_tok)) begin
              if (w_in0_vld && is_done(w_in0_tok)) begin
                if (r_pend_vld) begin
                  if (w_out0_space) begin
                    w_out0_push    = 1'b1;
                    w_out0_tok     = make_stop(r_pend_lvl);
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = ST_DONE;
                  end
                end else if (w_out0_space && w_out1_space) begin
                  w_out0_push = 1'b1;
                  w_out1_push = 1'b1;
                  w_in0_pop   = 1'b1;
                  w_in1_pop   = 1'b1;
                  w_fne_nxt   = 1'b0;
                end
              end
            end else if (w_in1_vld && is_stop(w_in1_tok)) begin
              if (w_out1_space) begin
                w_out1_push = 1'b1;
                w_in1_pop   = 1'b1;
              end
            end else if (w_in1_vld && is_data(w_in1_tok) && w_in0_vld) begin
              if (is_stop(w_in0_tok)) begin
                w_in0_pop = 1'b1;
                w_in1_pop = 1'b1;
                w_fne_nxt = 1'b0;
                if (r_fne) begin
                  w_pend_vld_nxt = 1'b1;
                  w_pend_lvl_nxt = stop_level(w_in0_tok);
                end else if (r_pend_vld) begin
                  if (stop_level(w_in0_tok) > r_pend_lvl) w_pend_lvl_nxt = stop_level(w_in0_tok);
                end else if (stop_level(w_in0_tok) != '0) begin
                  w_pend_vld_nxt = 1'b1;
                  w_pend_lvl_nxt = stop_level(w_in0_tok);
                end
              end else if (is_data(w_in0_tok)) begin
                if (r_pend_vld) begin
                  if (w_out0_space) begin
                    w_out0_push    = 1'b1;
                    w_out0_tok     = make_stop(r_pend_lvl);
                    w_pend_vld_nxt = 1'b0;
                  end
                end else if (!r_fne) begin
                  if (w_out1_space) begin
                    w_out1_push = 1'b1;
                    w_fne_nxt   = 1'b1;
                  end
                end else if (w_out0_space) begin
                  w_out0_push = 1'b1;
                  w_in0_pop   = 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            if (w_in0_vld && w_in1_vld && w_out0_space && w_out1_space) begin
              w_out0_push    = 1'b1;
              w_out1_push    = 1'b1;
              w_in0_pop      = 1'b1;
              w_in1_pop      = 1'b1;
              w_fne_nxt      = 1'b0;
              w_pend_vld_nxt = 1'b0;
              w_state_nxt    = ST_PROCESS;
            end
          end
          default: w_state_nxt = ST_PROCESS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coord_dropper.sv
// Scoreboard bench for coord_dropper: directed token vectors with hand-derived results.
module tb_coord_dropper;

  localparam int DN = -1000;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, tile_en, mode, cmrg_enable;
  logic [15:0] stop_lvl;
  logic [16:0] in0, in1;
  logic        in0_valid, in1_valid, in0_ready, in1_ready;
  logic [16:0] out0, out1;
  logic        out0_valid, out1_valid, out0_ready, out1_ready;

  int total = 0;
  int bad   = 0;

  logic [16:0] src0[$], src1[$], exp0[$], exp1[$];
  int          vi0[$], vi1[$], vo0[$], vo1[$];
  bit          bp_mode = 1'b0;
  bit          sink_hold = 1'b0;

  coord_dropper #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .cmrg_coord_in_0(in0), .cmrg_coord_in_0_valid(in0_valid), .cmrg_coord_in_0_ready(in0_ready),
    .cmrg_coord_in_1(in1), .cmrg_coord_in_1_valid(in1_valid), .cmrg_coord_in_1_ready(in1_ready),
    .cmrg_coord_out_0(out0), .cmrg_coord_out_0_valid(out0_valid), .cmrg_coord_out_0_ready(out0_ready),
    .cmrg_coord_out_1(out1), .cmrg_coord_out_1_valid(out1_valid), .cmrg_coord_out_1_ready(out1_ready),
    .cmrg_mode(mode), .cmrg_enable(cmrg_enable), .cmrg_stop_lvl(stop_lvl));

  always #5 clk = ~clk;

  // Vector shorthand: v>=0 data, -1-L stop level L, DN done.
  function automatic logic [16:0] tk(input int v);
    if (v == DN) return 17'h10100;
    if (v < 0) return {1'b1, 8'h00, 8'(-v - 1)};
    return {1'b0, 16'(v)};
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: compare every output transfer against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n && out0_valid && out0_ready) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL out0_extra actual=%h required=none", out0);
      end else chk("out0_tok", out0, exp0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && out1_valid && out1_ready) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL out1_extra actual=%h required=none", out1);
      end else chk("out1_tok", out1, exp1.pop_front());
    end
  end

  // Sink models: ready always, held low, or random under backpressure.
  initial begin
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out0_ready = !sink_hold && (!bp_mode || ($urandom_range(0, 3) != 0));
      out1_ready = !sink_hold && (!bp_mode || ($urandom_range(0, 2) != 0));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive0(input bit bp);
    int  g, n;
    bit  acc;
    @(posedge clk); #1;
    while (src0.size() != 0) begin
      if (bp) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      in0 = src0.pop_front();
      in0_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk); acc = in0_ready;
        @(posedge clk); #1; n++;
      end while (!acc && n < 2000);
      in0_valid = 1'b0;
      if (!acc) begin
        total++; bad++;
        $display("FAIL in0_accept actual=stuck required=ready");
        src0.delete();
      end
    end
  endtask

  task automatic drive1(input bit bp);
    int  g, n;
    bit  acc;
    @(posedge clk); #1;
    while (src1.size() != 0) begin
      if (bp) begin
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
      end
      in1 = src1.pop_front();
      in1_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk); acc = in1_ready;
        @(posedge clk); #1; n++;
      end while (!acc && n < 2000);
      in1_valid = 1'b0;
      if (!acc) begin
        total++; bad++;
        $display("FAIL in1_accept actual=stuck required=ready");
        src1.delete();
      end
    end
  endtask

  task automatic load_vectors();
    foreach (vi0[i]) src0.push_back(tk(vi0[i]));
    foreach (vi1[i]) src1.push_back(tk(vi1[i]));
    foreach (vo0[i]) exp0.push_back(tk(vo0[i]));
    foreach (vo1[i]) exp1.push_back(tk(vo1[i]));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 4000) begin
      @(posedge clk); n++;
    end
    total++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      bad++;
      $display("FAIL drain actual=left0:%0d,left1:%0d required=0,0", exp0.size(), exp1.size());
      exp0.delete();
      exp1.delete();
    end
  endtask

  task automatic run_scen(input bit bp);
    bp_mode = bp;
    load_vectors();
    fork
      drive0(bp);
      drive1(bp);
    join
    wait_drain();
    bp_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic set_s1();
    vi1 = '{0, 1, 2, -1, DN};
    vi0 = '{1, -1, -1, 3, -2, DN};
    vo1 = '{0, 2, -1, DN};
    vo0 = '{1, -1, 3, -2, DN};
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1; mode = 1'b1;
    cmrg_enable = 1'b0; stop_lvl = 16'h0;
    in0 = '0; in1 = '0; in0_valid = 1'b0; in1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out0_valid", {16'h0, out0_valid}, 17'h0);
    chk("rst_out1_valid", {16'h0, out1_valid}, 17'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in0_ready", {16'h0, in0_ready}, 17'h1);
    chk("rst_in1_ready", {16'h0, in1_ready}, 17'h1);

    // Passthrough with held sink, then tile_en gating of every handshake output.
    mode = 1'b0;
    sink_hold = 1'b1;
    vi0 = '{66, -3}; vo0 = '{66, -3};
    vi1 = '{DN};     vo1 = '{DN};
    load_vectors();
    fork
      drive0(1'b0);
      drive1(1'b0);
    join
    repeat (4) @(posedge clk);
    #1;
    tile_en = 1'b0;
    #1;
    chk("tile_out0_valid", {16'h0, out0_valid}, 17'h0);
    chk("tile_out1_valid", {16'h0, out1_valid}, 17'h0);
    chk("tile_in0_ready", {16'h0, in0_ready}, 17'h0);
    chk("tile_in1_ready", {16'h0, in1_ready}, 17'h0);
    tile_en = 1'b1;
    #1;
    chk("tile_back_out0_valid", {16'h0, out0_valid}, 17'h1);
    sink_hold = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;

    // Drop mode directed scenarios.
    mode = 1'b1;
    set_s1();
    run_scen(1'b0);

    vi1 = '{0, 1, -1, DN};     vi0 = '{5, -1, -2, DN};
    vo1 = '{0, -1, DN};        vo0 = '{5, -2, DN};
    run_scen(1'b0);

    vi1 = '{4, 7, -1, DN};     vi0 = '{1, 2, -1, 3, -2, DN};
    vo1 = '{4, 7, -1, DN};     vo0 = '{1, 2, -1, 3, -2, DN};
    run_scen(1'b0);

    vi1 = '{0, 1, -1, DN};     vi0 = '{-1, -2, DN};
    vo1 = '{-1, DN};           vo0 = '{-2, DN};
    run_scen(1'b0);

    // Random gaps and backpressure on all four ports.
    set_s1();
    run_scen(1'b1);
    set_s1();
    run_scen(1'b1);
    vi1 = '{0, 1, -1, DN};     vi0 = '{5, -1, -2, DN};
    vo1 = '{0, -1, DN};        vo0 = '{5, -2, DN};
    run_scen(1'b1);

    // Flush after three transfers, then replay scenario 1.
    sink_hold = 1'b1;
    src1.push_back(tk(0));
    src1.push_back(tk(1));
    src0.push_back(tk(1));
    fork
      drive0(1'b0);
      drive1(1'b0);
    join
    repeat (5) @(posedge clk);
    #1;
    chk("flush_pre_out1_valid", {16'h0, out1_valid}, 17'h1);
    chk("flush_pre_out1_tok", out1, tk(0));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out0_valid", {16'h0, out0_valid}, 17'h0);
    chk("flush_out1_valid", {16'h0, out1_valid}, 17'h0);
    sink_hold = 1'b0;
    set_s1();
    run_scen(1'b0);

    // Asynchronous reset mid-stream, then replay scenario 1.
    sink_hold = 1'b1;
    src1.push_back(tk(4));
    src1.push_back(tk(7));
    src0.push_back(tk(1));
    fork
      drive0(1'b0);
      drive1(1'b0);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("arst_pre_out1_valid", {16'h0, out1_valid}, 17'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out0_valid", {16'h0, out0_valid}, 17'h0);
    chk("arst_out1_valid", {16'h0, out1_valid}, 17'h0);
    #12;
    rst_n = 1'b1;
    sink_hold = 1'b0;
    set_s1();
    run_scen(1'b0);

    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
